updown_counter_display: RTL

UPDOWN_COUNTER_DISPLAY -- requirements
Module: updown_counter_display

---
 rtl/sseg_pkg.sv | 33 +++
 rtl/updown_counter_display_if.sv | 26 ++
 rtl/bin2bcd_seq.sv | 91 +++++++++
 rtl/updown_counter_display.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the up/down counter display: seven-segment code
// table, converter FSM states and a digits-vs-width sanity check.
package sseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; codes 10-15 are blank.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, SEG_BLANK,  SEG_BLANK,
    SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
  function automatic bit digits_ok(input int width, input int digits);
    longint unsigned pow10;
    longint unsigned max_bin;
    pow10 = 64'd1;
    for (int i = 0; i < digits; i++) begin
      pow10 = pow10 * 64'd10;
    end
    max_bin = (64'd1 << width) - 64'd1;
    return pow10 > max_bin;
  endfunction

endpackage

// File: rtl/updown_counter_display_if.sv
// Signal bundle around updown_counter_display: button levels and load data
// towards the counter, counter value, BCD and display drive back.
interface updown_counter_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  up;
  logic                  down;
  logic                  load;
  logic [WIDTH-1:0]      din;
  logic [WIDTH-1:0]      count;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     AN;
  logic [6:0]            sseg;
  logic                  DP;

  modport master (
    output up, down, load, din,
    input  count, bcd, AN, sseg, DP
  );

  modport slave (
    input  up, down, load, din,
    output count, bcd, AN, sseg, DP
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: captures bin, shifts WIDTH times with
// add-3 correction, then publishes the whole BCD word at once.
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    bin,
  output logic [4*DIGITS-1:0] bcd,
  output logic                done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int BCD_W = 4 * DIGITS;

  bcd_state_t       state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [BCD_W-1:0] work_reg, work_next;
  logic [BCD_W-1:0] work_adj;
  logic [BCD_W-1:0] bcd_reg, bcd_next;
  logic [CNT_W-1:0] iter_reg, iter_next;
  logic             done_reg, done_next;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign work_adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5)
                                 ? work_reg[4*gi +: 4] + 4'd3
                                 : work_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      work_reg  <= '0;
      iter_reg  <= '0;
      bcd_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      work_reg  <= work_next;
      iter_reg  <= iter_next;
      bcd_reg   <= bcd_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    work_next  = work_reg;
    iter_next  = iter_reg;
    bcd_next   = bcd_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        shift_next = bin;
        work_next  = '0;
        iter_next  = '0;
        state_next = SHIFT;
      end
      SHIFT: begin
        // Correct every nibble, then shift the next binary MSB into the BCD word.
        work_next  = {work_adj[BCD_W-2:0], shift_reg[WIDTH-1]};
        shift_next = shift_reg << 1;
        iter_next  = iter_reg + CNT_W'(1);
        if (iter_reg == CNT_W'(WIDTH - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bcd_next   = work_reg;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bcd  = bcd_reg;
  assign done = done_reg;

endmodule

// File: rtl/updown_counter_display.sv
// Button-driven up/down/load counter with continuous BCD conversion and a
// multiplexed seven-segment driver. Optional SSEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
module updown_counter_display
  import sseg_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 100000,
  parameter int SATURATE    = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                up,
  input  logic                down,
  input  logic                load,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    count,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   AN,
  output logic [6:0]          sseg,
  output logic                DP
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  generate
    if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
      $error("DIGITS cannot represent every WIDTH-bit value");
    end
    if (REFRESH_DIV < 2) begin : g_bad_div
      $error("REFRESH_DIV must be at least 2");
    end
  endgenerate

  // ---------------- counter ----------------
  logic             up_prev_reg, down_prev_reg, load_prev_reg;
  logic             up_evt, down_evt, load_evt;
  logic [WIDTH-1:0] count_reg, count_next;

  assign up_evt   = up   & ~up_prev_reg;
  assign down_evt = down & ~down_prev_reg;
  assign load_evt = load & ~load_prev_reg;

  always_comb begin
    count_next = count_reg;
    if (load_evt) begin
      count_next = din;
    end else if (up_evt && !down_evt) begin
      if (count_reg == MAX_COUNT) begin
        count_next = (SATURATE != 0) ? MAX_COUNT : '0;
      end else begin
        count_next = count_reg + WIDTH'(1);
      end
    end else if (down_evt && !up_evt) begin
      if (count_reg == '0) begin
        count_next = (SATURATE != 0) ? '0 : MAX_COUNT;
      end else begin
        count_next = count_reg - WIDTH'(1);
      end
    end
  end

  // Edge registers start high so a button held through reset is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_prev_reg   <= 1'b1;
      down_prev_reg <= 1'b1;
      load_prev_reg <= 1'b1;
      count_reg     <= '0;
    end else begin
      up_prev_reg   <= up;
      down_prev_reg <= down;
      load_prev_reg <= load;
      count_reg     <= count_next;
    end
  end

  // ---------------- conversion ----------------
  logic [4*DIGITS-1:0] bcd_w;
  logic                conv_done;

  bin2bcd_seq #(
    .WIDTH (WIDTH),
    .DIGITS(DIGITS)
  ) u_conv (
    .clk  (clk),
    .reset(reset),
    .bin  (count_reg),
    .bcd  (bcd_w),
    .done (conv_done)
  );

  // ---------------- display ----------------
  logic [PRE_W-1:0]  presc_reg;
  logic [IDX_W-1:0]  digit_reg, digit_next;
  logic [DIGITS-1:0] an_reg, an_next;
  logic [6:0]        sseg_reg, sseg_next;
  logic              tick;
  logic [3:0]        nibble [DIGITS];
  logic [3:0]        sel_nibble;
  logic [DIGITS-1:0] blank_mask;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign nibble[gi] = bcd_w[4*gi +: 4];
    end
  endgenerate

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic zero_above;
    blank_mask = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above && (nibble[i] == 4'd0);
      blank_mask[i] = zero_above;
    end
  end
`else
  assign blank_mask = '0;
`endif

  assign tick       = (presc_reg == PRE_W'(REFRESH_DIV - 1));
  assign digit_next = !tick ? digit_reg
                    : (digit_reg == IDX_W'(DIGITS - 1)) ? '0
                    : digit_reg + IDX_W'(1);
  assign an_next    = ~(DIGITS'(1) << digit_next);
  assign sel_nibble = nibble[digit_next];
  assign sseg_next  = blank_mask[digit_next] ? SEG_BLANK : SEG_TABLE[sel_nibble];

  // Segments reload only on a digit change or a fresh BCD word, so each
  // digit's pattern switches in a single clean register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg <= '0;
      digit_reg <= '0;
      an_reg    <= ~DIGITS'(1);
      sseg_reg  <= SEG_TABLE[0];
    end else begin
      presc_reg <= tick ? '0 : presc_reg + PRE_W'(1);
      digit_reg <= digit_next;
      if (tick || conv_done) begin
        an_reg   <= an_next;
        sseg_reg <= sseg_next;
      end
    end
  end

  assign count = count_reg;
  assign bcd   = bcd_w;
  assign AN    = an_reg;
  assign sseg  = sseg_reg;
  assign DP    = 1'b1;

endmodule
